// File: rtl/axi_burst_rd_master.sv
// AXI4 read initiator: streams a contiguous block of words from an AXI slave, split into INCR bursts.
// Optional macro AXI_4K_SPLIT_EN additionally stops any burst at a 4 KB boundary.
module axi_burst_rd_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic              m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int SIZE = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic [8:0]        burst_beats_q, burst_beats_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              error_q, error_d;
    logic              load_ar;
    logic [12:0]       room_d;
    logic [8:0]        beats_next;
    logic              r_hs;
    logic              unused_rid;

    // Beats in the next burst: limited by words left, MAX_BURST and the room allowance.
    function automatic logic [8:0] burst_len(input logic [LEN_W-1:0] rem, input logic [12:0] room);
        logic [8:0] b;
        if (rem < LEN_W'(MAX_BURST)) b = 9'(rem);
        else                         b = 9'(MAX_BURST);
        if ({4'd0, b} > room) b = 9'(room);
        return b;
    endfunction

    assign unused_rid = m_axi_rid;
    assign r_hs       = m_axi_rvalid & m_axi_rready;

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        beat_cnt_d    = beat_cnt_q;
        burst_beats_d = burst_beats_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        error_d       = error_q;
        load_ar       = 1'b0;
        room_d        = 13'h1FFF;
        beats_next    = 9'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    if (len != '0) begin
                        cur_addr_d  = addr;
                        remaining_d = len;
                        load_ar     = 1'b1;
                        state_d     = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                if (m_axi_arready) begin
                    beat_cnt_d = burst_beats_q;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs) begin
                    beat_cnt_d  = beat_cnt_q - 9'd1;
                    remaining_d = remaining_q - 1'b1;
                    if (m_axi_rresp != 2'b00) error_d = 1'b1;
                    if (m_axi_rlast != (beat_cnt_q == 9'd1)) error_d = 1'b1;
                    // The local counter, not rlast, decides where the burst ends.
                    if (beat_cnt_q == 9'd1) begin
                        cur_addr_d = cur_addr_q + (ADDR_W'(burst_beats_q) << SIZE);
                        if (remaining_d != '0) begin
                            load_ar = 1'b1;
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (load_ar) begin
`ifdef AXI_4K_SPLIT_EN
            room_d = (13'd4096 - {1'b0, cur_addr_d[11:0]}) >> SIZE;
`endif
            beats_next    = burst_len(remaining_d, room_d);
            burst_beats_d = beats_next;
            araddr_d      = cur_addr_d;
            arlen_d       = 8'(beats_next - 9'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            error_q  <= 1'b0;
            araddr_q <= '0;
            arlen_q  <= '0;
        end else begin
            state_q  <= state_d;
            error_q  <= error_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
        end
    end

    always_ff @(posedge clk) begin
        cur_addr_q    <= cur_addr_d;
        remaining_q   <= remaining_d;
        beat_cnt_q    <= beat_cnt_d;
        burst_beats_q <= burst_beats_d;
    end

    assign busy          = (state_q == S_ADDR) || (state_q == S_DATA);
    assign done          = (state_q == S_DONE);
    assign error         = error_q;
    assign m_axi_arid    = 1'b0;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (state_q == S_ADDR);
    // Zero-latency pass-through: the sink's ready is the slave's ready.
    assign m_axi_rready  = (state_q == S_DATA) & out_ready;
    assign out_valid     = (state_q == S_DATA) & m_axi_rvalid;
    assign out_data      = (state_q == S_DATA) ? m_axi_rdata : '0;
endmodule

// File: tb/tb_axi_burst_rd_master.sv
// Self-checking bench for axi_burst_rd_master: table-driven transactions against an AXI slave model
// with data/AR scoreboards, plus hand-written reset, len=0 and ignored-start sequences.
module tb_axi_burst_rd_master;
    localparam int MAX_BURST = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] len = '0;
    logic        busy, done, error;
    logic        arid, arlock, arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic [3:0]  arcache, arqos;
    logic        arready = 1'b0;
    logic        rid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    axi_burst_rd_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .error(error),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
        .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_data_q[$];
    logic [39:0] exp_ar_q[$];
    int          ar_wait_cfg = 0, ar_wait_cnt = 0;
    bit          toggle_mode = 1'b0;
    bit          s_active = 1'b0;
    logic [31:0] s_addr = '0;
    int          s_len = 0, s_idx = 0, g_beat = 0;
    int          err_beat = -1, rlast_bad = -1, done_cnt = 0;

    typedef struct {
        logic [31:0] a;
        int          n;
        int          w;
        bit          t;
        int          e;
        int          rb;
        int          poke;
        bit          exp_err;
    } vec_t;
    vec_t vecs[9];

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got unexpected event, expected none", name);
    endtask

    task automatic push_expected(input logic [31:0] a, input int n);
        logic [31:0] cur;
        int          rem, b;
        cur = a;
        rem = n;
        for (int i = 0; i < n; i++) exp_data_q.push_back(pattern(a + 32'(4 * i)));
        while (rem > 0) begin
            b = (rem < MAX_BURST) ? rem : MAX_BURST;
`ifdef AXI_4K_SPLIT_EN
            if (b > (4096 - int'(cur[11:0])) / 4) b = (4096 - int'(cur[11:0])) / 4;
`endif
            exp_ar_q.push_back({8'(b - 1), cur});
            cur = cur + 32'(b * 4);
            rem -= b;
        end
    endtask

    // One clock: drive slave/sink just after a falling edge, settle, then score the coming rising edge.
    task automatic cycle();
        if (arvalid && !s_active) begin
            arready = (ar_wait_cnt >= ar_wait_cfg);
            if (!arready) ar_wait_cnt++;
        end else begin
            arready = 1'b0;
        end
        if (s_active) begin
            rvalid = 1'b1;
            rdata  = pattern(s_addr + 32'(4 * s_idx));
            rresp  = (g_beat == err_beat) ? 2'b10 : 2'b00;
            rlast  = (s_idx == s_len - 1) ^ (g_beat == rlast_bad);
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rresp  = 2'b00;
            rlast  = 1'b0;
        end
        out_ready = toggle_mode ? ~out_ready : 1'b1;
        #1;
        if (s_active) chk("rready_mirror", rready, out_ready);
        if (out_valid && out_ready) begin
            if (exp_data_q.size() == 0) note_fail("out_extra_beat");
            else chk("out_data", out_data, exp_data_q.pop_front());
        end
        if (rvalid && rready) begin
            s_idx++;
            g_beat++;
            if (s_idx == s_len) s_active = 1'b0;
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done", busy, 0);
        end
        if (arvalid) begin
            chk("ar_outstanding", s_active, 0);
            if (exp_ar_q.size() == 0) begin
                note_fail("ar_unexpected");
            end else begin
                chk("araddr", araddr, exp_ar_q[0][31:0]);
                chk("arlen", arlen, exp_ar_q[0][39:32]);
            end
            if (arready) begin
                if (exp_ar_q.size() != 0) void'(exp_ar_q.pop_front());
                s_active    = 1'b1;
                s_addr      = araddr;
                s_len       = int'(arlen) + 1;
                s_idx       = 0;
                ar_wait_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_txn(input vec_t v);
        ar_wait_cfg = v.w;
        ar_wait_cnt = 0;
        toggle_mode = v.t;
        err_beat    = v.e;
        rlast_bad   = v.rb;
        g_beat      = 0;
        done_cnt    = 0;
        push_expected(v.a, v.n);
        start = 1'b1;
        addr  = v.a;
        len   = 16'(v.n);
        cycle();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("arvalid_latency", arvalid, 1);
        chk("error_cleared", error, 0);
        for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
            if (c == v.poke) begin
                start = 1'b1;
                addr  = 32'h9000;
                len   = 16'd3;
            end
            cycle();
            start = 1'b0;
        end
        chk("done_seen", done_cnt, 1);
        cycle();
        cycle();
        chk("done_once", done_cnt, 1);
        chk("error_final", error, v.exp_err);
        chk("words_left", exp_data_q.size(), 0);
        chk("ars_left", exp_ar_q.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_0100, 16, 0, 1'b0, -1, -1, -1, 1'b0};
        vecs[1] = '{32'h0000_0000, 40, 0, 1'b0, -1, -1, -1, 1'b0};
        vecs[2] = '{32'h0000_2000, 20, 3, 1'b1, -1, -1, -1, 1'b0};
        vecs[3] = '{32'h0000_0300,  8, 0, 1'b0,  4, -1, -1, 1'b1};
        vecs[4] = '{32'h0000_0400, 17, 1, 1'b0, -1, -1,  6, 1'b0};
        vecs[5] = '{32'h0000_0FF8,  8, 0, 1'b0, -1, -1, -1, 1'b0};
        vecs[6] = '{32'hFFFF_FFC0, 20, 2, 1'b1, -1, -1, -1, 1'b0};
        vecs[7] = '{32'h0000_0600,  3, 0, 1'b0, -1,  2, -1, 1'b1};
        vecs[8] = '{32'h0000_0500,  4, 0, 1'b0, -1,  1, -1, 1'b1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("const_arsize", arsize, 3'd2);
        chk("const_arburst", arburst, 2'b01);
        chk("const_arcache", arcache, 4'b0011);
        chk("const_misc", {arid, arlock, arprot, arqos}, 0);
        rst = 1'b1;
        cycle();

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // len=0 after an errored transfer, then a start during the DONE cycle
        done_cnt    = 0;
        toggle_mode = 1'b0;
        start = 1'b1;
        addr  = 32'h700;
        len   = 16'd0;
        cycle();
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_arvalid", arvalid, 0);
        chk("len0_err_clr", error, 0);
        addr = 32'h800;
        len  = 16'd4;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        chk("done_start_ignored_done", done_cnt, 1);
        chk("done_start_ignored_arv", arvalid, 0);
        chk("done_start_ignored_busy", busy, 0);

        // reset in the middle of the second burst
        ar_wait_cfg = 0;
        err_beat    = -1;
        rlast_bad   = -1;
        g_beat      = 0;
        push_expected(32'h0, 40);
        start = 1'b1;
        addr  = 32'h0;
        len   = 16'd40;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 200 && g_beat < 20; c++) cycle();
        chk("beats_before_reset", g_beat, 20);
        rst      = 1'b0;
        s_active = 1'b0;
        cycle();
        rst = 1'b1;
        exp_data_q.delete();
        exp_ar_q.delete();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_araddr", araddr, 0);
        chk("mid_rst_arlen", arlen, 0);
        done_cnt = 0;
        start = 1'b1;
        addr  = 32'h40;
        len   = 16'd0;
        cycle();
        start = 1'b0;
        chk("post_rst_len0_done", done, 1);
        chk("post_rst_len0_arvalid", arvalid, 0);
        repeat (3) cycle();
        chk("post_rst_done_once", done_cnt, 1);
        chk("post_rst_idle_arvalid", arvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/axi_burst_rd_master.md
Name: axi_burst_rd_master

Overview:
- AXI4 read-channel initiator: fetches a contiguous block of DDR words into a local ready/valid stream.
- Sits between an accelerator datapath and the system DDR AXI port; it is the master end that drives the existing axi_ram DDR model in simulation.
- Splits a request into INCR bursts of at most MAX_BURST beats, tracks beats, flags response errors.

Parameters:
- ADDR_W, 32, AXI byte address width.
- DATA_W, 32, data width; fixed arsize = log2(DATA_W/8).
- LEN_W, 16, width of the request word count.
- MAX_BURST, 16, max beats per burst (1..256).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- addr  in  ADDR_W  start byte address, DATA_W/8-aligned.
- len  in  LEN_W  number of words to read.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at request completion.
- error  out  1  sticky: rresp!=OKAY or rlast mismatch; cleared by accepted start.
- m_axi_arid  out  1  constant 0.
- m_axi_araddr  out  ADDR_W  burst address.
- m_axi_arlen  out  8  beats-1.
- m_axi_arsize  out  3  log2(DATA_W/8).
- m_axi_arburst  out  2  constant 01 (INCR).
- m_axi_arlock  out  1  constant 0.
- m_axi_arcache  out  4  constant 0011.
- m_axi_arprot  out  3  constant 000.
- m_axi_arqos  out  4  constant 0000.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address accepted.
- m_axi_rid  in  1  ignored.
- m_axi_rdata  in  DATA_W  read data.
- m_axi_rresp  in  2  response.
- m_axi_rlast  in  1  last beat.
- m_axi_rvalid  in  1  data valid.
- m_axi_rready  out  1  data accept.
- out_data  out  DATA_W  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream accept.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; busy, done, arvalid, rready, out_valid, error = 0; araddr, arlen = 0. Reset mid-burst abandons the transfer immediately; the slave's outstanding beats are not drained.
- IDLE: start=1 and len!=0 latches addr into cur_addr and len into remaining, clears error, sets busy, goes to ADDR next cycle. start=1 and len=0: no AR is issued; done pulses next cycle; error is cleared; busy stays 0. start while busy is ignored.
- ADDR: beats = min(remaining, MAX_BURST). arlen = beats-1 and araddr = cur_addr are registered on entry. arvalid stays high, with araddr/arlen stable, until arready. Handshake cycle: arvalid drops, beat_cnt = beats, go to DATA.
- DATA: combinational pass-through. out_valid = rvalid, out_data = rdata, rready = out_ready. No buffering; zero added latency.
- Beat transfer (rvalid & rready):
  - beat_cnt decrements, remaining decrements.
  - rresp!=00 sets error.
  - rlast asserted while beat_cnt!=1, or deasserted while beat_cnt==1, sets error.
  - The burst ends on the counter regardless of rlast.
- Burst end: cur_addr += beats*DATA_W/8 (ADDR_W wrap-around, no saturation). If remaining!=0, go to ADDR; otherwise go to DONE.
- DONE: done=1 for one cycle, busy=0, go to IDLE. A start in the DONE cycle is ignored.
- Single outstanding burst only. The next AR is never issued before the last R beat of the current burst.
- Latency: arvalid rises 1 cycle after start. Each subsequent burst's arvalid rises 1 cycle after the previous burst's last beat.

Optional Feature:
- Macro: AXI_4K_SPLIT_EN.
- Defined: beats = min(remaining, MAX_BURST, (4096 - cur_addr[11:0])/(DATA_W/8)), so no burst crosses a 4 KB boundary.
- Undefined: beats = min(remaining, MAX_BURST); callers guarantee no 4 KB crossing.

Test Plan:
- addr=0x100, len=16, arready/rvalid/out_ready always 1 -> one AR (araddr 0x100, arlen 15), 16 words out, done pulses once, error=0.
- addr=0x0, len=40, MAX_BURST=16 -> ARs at 0x0/arlen 15, 0x40/arlen 15, 0x80/arlen 7; 40 words in order.
- len=20, out_ready toggling 1-0, arready delayed 3 cycles -> araddr/arlen stable while arvalid high; no beat lost or duplicated; rready mirrors out_ready.
- Beat 5 of 8 returns rresp=10 -> error=1 after that beat; all 8 words still streamed; done pulses; next start clears error.
- With AXI_4K_SPLIT_EN, addr=0xFF8, len=8 -> ARs at 0xFF8/arlen 1 and 0x1000/arlen 5. Without the macro -> single AR at 0xFF8/arlen 7.
- rst=0 in the middle of the 2nd burst, then len=0 start -> all outputs 0 after reset; the len=0 start gives a done pulse with no arvalid.
